// File: rtl/sdram_ctrl_aardonyx.sv
// sdram_ctrl_aardonyx: single-port close-page controller for a 32-bit SDR SDRAM.
// Runs the power-up sequence, schedules periodic auto-refresh and serves one-word
// read/write requests (ACTIVE, then READ/WRITE with auto-precharge).
// Optional feature macro: SDRAM_FAST_INIT_EN shortens the power-up NOP wait to 16 cycles.
module sdram_ctrl_aardonyx #(
    parameter int unsigned ADDR_BITS    = 13,
    parameter int unsigned COL_BITS     = 9,
    parameter int unsigned BA_BITS      = 2,
    parameter int unsigned DQ_BITS      = 32,
    parameter int unsigned DM_BITS      = 4,
    parameter int unsigned T_INIT_CYC   = 20000,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned CAS_LAT      = 3,
    parameter int unsigned REF_INTERVAL = 780,
    parameter logic [ADDR_BITS-1:0] MODE_REG = 13'h030
) (
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_write,
    input  logic [ADDR_BITS+BA_BITS+COL_BITS-1:0]  req_addr,
    input  logic [DQ_BITS-1:0]                     req_wdata,
    input  logic [DM_BITS-1:0]                     req_wmask,
    output logic                                   rsp_valid,
    output logic [DQ_BITS-1:0]                     rsp_rdata,
    output logic                                   init_done,
    output logic                                   sdr_cke,
    output logic                                   sdr_cs_n,
    output logic                                   sdr_ras_n,
    output logic                                   sdr_cas_n,
    output logic                                   sdr_we_n,
    output logic [ADDR_BITS-1:0]                   sdr_addr,
    output logic [BA_BITS-1:0]                     sdr_ba,
    output logic [DM_BITS-1:0]                     sdr_dqm,
    output logic [DQ_BITS-1:0]                     sdr_dq_out,
    output logic                                   sdr_dq_oe,
    input  logic [DQ_BITS-1:0]                     sdr_dq_in
);

`ifdef SDRAM_FAST_INIT_EN
    localparam int unsigned INIT_CYC = 16;
`else
    localparam int unsigned INIT_CYC = T_INIT_CYC;
`endif

    // One shared down-counter; sized to hold the longest wait with margin.
    localparam int unsigned CNT_MAX = INIT_CYC + T_RP + T_RCD + T_RFC + T_MRD + T_WR + CAS_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned REF_W   = $clog2(REF_INTERVAL + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [3:0] {
        StInitWait,
        StInitPre,
        StInitRef1,
        StInitRef2,
        StInitMrs,
        StIdle,
        StRefresh,
        StActivate,
        StRw,
        StRdWait,
        StWrRec
    } state_e;

    state_e                                 state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [3:0]                             cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]                   addr_q, addr_d;
    logic [BA_BITS-1:0]                     ba_q, ba_d;
    logic [DM_BITS-1:0]                     dqm_q, dqm_d;
    logic [DQ_BITS-1:0]                     dq_out_q, dq_out_d;
    logic                                   dq_oe_q, dq_oe_d;
    logic                                   cke_q, cke_d;
    logic                                   rsp_valid_q, rsp_valid_d;
    logic [DQ_BITS-1:0]                     rsp_rdata_q, rsp_rdata_d;
    logic                                   init_done_q, init_done_d;
    logic [REF_W-1:0]                       ref_cnt_q, ref_cnt_d;
    logic                                   ref_pending_q, ref_pending_d;
    logic                                   lat_write_q, lat_write_d;
    logic [ADDR_BITS+BA_BITS+COL_BITS-1:0]  lat_addr_q, lat_addr_d;
    logic [DQ_BITS-1:0]                     lat_wdata_q, lat_wdata_d;
    logic [DM_BITS-1:0]                     lat_wmask_q, lat_wmask_d;
    logic                                   ref_clr;
    logic                                   ref_expire;

    // Column command address: column bits plus A10 for auto-precharge.
    logic [ADDR_BITS-1:0] col_addr;

    // Column address for the latched request, with auto-precharge set.
    always_comb begin
        col_addr               = '0;
        col_addr[COL_BITS-1:0] = lat_addr_q[COL_BITS-1:0];
        col_addr[10]           = 1'b1;
    end

    // Ready depends only on state and pending refresh, never on req_valid.
    always_comb begin
        req_ready = (state_q == StIdle) && !ref_pending_q;
    end

    // Refresh interval counter; runs once init is done, holds a single pending refresh.
    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_expire = 1'b0;
        if (init_done_q) begin
            if (ref_cnt_q == REF_W'(REF_INTERVAL - 1)) begin
                ref_cnt_d  = '0;
                ref_expire = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + REF_W'(1);
            end
        end
        if (ref_clr) begin
            ref_pending_d = 1'b0;
        end else if (ref_expire) begin
            ref_pending_d = 1'b1;
        end else begin
            ref_pending_d = ref_pending_q;
        end
    end

    // Main sequencer: next state, counter and registered SDRAM command/data outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = CMD_NOP;
        addr_d      = addr_q;
        ba_d        = ba_q;
        dqm_d       = '1;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        cke_d       = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;
        lat_write_d = lat_write_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_wmask_d = lat_wmask_q;
        ref_clr     = 1'b0;

        unique case (state_q)
            StInitWait: begin
                if (cnt_q == '0) begin
                    cmd_d      = CMD_PRE;
                    addr_d     = '0;
                    addr_d[10] = 1'b1;
                    cnt_d      = CNT_W'(T_RP - 1);
                    state_d    = StInitPre;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StInitPre: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    cnt_d   = CNT_W'(T_RFC - 1);
                    state_d = StInitRef1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StInitRef1: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    cnt_d   = CNT_W'(T_RFC - 1);
                    state_d = StInitRef2;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StInitRef2: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_LMR;
                    addr_d  = MODE_REG;
                    ba_d    = '0;
                    cnt_d   = CNT_W'(T_MRD - 1);
                    state_d = StInitMrs;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StInitMrs: begin
                if (cnt_q == '0) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StIdle: begin
                if (ref_pending_q) begin
                    cmd_d   = CMD_REF;
                    ref_clr = 1'b1;
                    cnt_d   = CNT_W'(T_RFC - 1);
                    state_d = StRefresh;
                end else if (req_valid) begin
                    lat_write_d = req_write;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    lat_wmask_d = req_wmask;
                    cmd_d       = CMD_ACT;
                    addr_d      = req_addr[ADDR_BITS+BA_BITS+COL_BITS-1:BA_BITS+COL_BITS];
                    ba_d        = req_addr[BA_BITS+COL_BITS-1:COL_BITS];
                    cnt_d       = CNT_W'(T_RCD - 1);
                    state_d     = StActivate;
                end
            end
            StRefresh: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StActivate: begin
                if (cnt_q == '0) begin
                    addr_d  = col_addr;
                    ba_d    = lat_addr_q[BA_BITS+COL_BITS-1:COL_BITS];
                    state_d = StRw;
                    if (lat_write_q) begin
                        cmd_d    = CMD_WRITE;
                        dq_oe_d  = 1'b1;
                        dq_out_d = lat_wdata_q;
                        dqm_d    = ~lat_wmask_q;
                    end else begin
                        cmd_d = CMD_READ;
                        dqm_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRw: begin
                if (lat_write_q) begin
                    cnt_d   = CNT_W'(T_WR + T_RP - 1);
                    state_d = StWrRec;
                end else begin
                    // Count one past capture so the response cycle is not IDLE.
                    dqm_d   = '0;
                    cnt_d   = CNT_W'(CAS_LAT);
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                dqm_d = (cnt_q > CNT_W'(1)) ? '0 : '1;
                if (cnt_q == CNT_W'(1)) begin
                    rsp_rdata_d = sdr_dq_in;
                    rsp_valid_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWrRec: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StInitWait;
                cnt_d   = CNT_W'(INIT_CYC);
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= StInitWait;
            cnt_q         <= CNT_W'(INIT_CYC);
            cmd_q         <= CMD_DESEL;
            addr_q        <= '0;
            ba_q          <= '0;
            dqm_q         <= '1;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            cke_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            init_done_q   <= 1'b0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            lat_write_q   <= 1'b0;
            lat_addr_q    <= '0;
            lat_wdata_q   <= '0;
            lat_wmask_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            ba_q          <= ba_d;
            dqm_q         <= dqm_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            cke_q         <= cke_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            init_done_q   <= init_done_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            lat_write_q   <= lat_write_d;
            lat_addr_q    <= lat_addr_d;
            lat_wdata_q   <= lat_wdata_d;
            lat_wmask_q   <= lat_wmask_d;
        end
    end

    // Port mapping of the registered outputs.
    always_comb begin
        sdr_cs_n   = cmd_q[3];
        sdr_ras_n  = cmd_q[2];
        sdr_cas_n  = cmd_q[1];
        sdr_we_n   = cmd_q[0];
        sdr_addr   = addr_q;
        sdr_ba     = ba_q;
        sdr_dqm    = dqm_q;
        sdr_dq_out = dq_out_q;
        sdr_dq_oe  = dq_oe_q;
        sdr_cke    = cke_q;
        rsp_valid  = rsp_valid_q;
        rsp_rdata  = rsp_rdata_q;
        init_done  = init_done_q;
    end

endmodule

// File: tb/tb_sdram_ctrl_aardonyx.sv
// Bench for sdram_ctrl_aardonyx: directed requests against a small behavioural SDRAM,
// with every bus cycle logged and compared to hand-computed cycle numbers.
module tb_sdram_ctrl_aardonyx;

    localparam int unsigned CL = 3;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_valid, init_done;
    logic [31:0] rsp_rdata;
    logic        sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic [3:0]  sdr_dqm;
    logic [31:0] sdr_dq_out;
    logic        sdr_dq_oe;
    logic [31:0] sdr_dq_in = '0;

    sdram_ctrl_aardonyx #(.T_INIT_CYC(100)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
        .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_addr(sdr_addr),
        .sdr_ba(sdr_ba), .sdr_dqm(sdr_dqm), .sdr_dq_out(sdr_dq_out),
        .sdr_dq_oe(sdr_dq_oe), .sdr_dq_in(sdr_dq_in)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    // Per-cycle bus log, indexed by absolute cycle number.
    logic [3:0]  cmd_at   [4096];
    logic [12:0] addr_at  [4096];
    logic [1:0]  ba_at    [4096];
    logic [3:0]  dqm_at   [4096];
    logic        oe_at    [4096];
    logic [31:0] dout_at  [4096];
    logic        rsp_at   [4096];
    logic [31:0] rdata_at [4096];
    logic        idone_at [4096];
    int          rsp_count = 0;

    // Behavioural SDRAM: open row per bank, byte-masked writes, CL-cycle read pipeline.
    logic [31:0] mem [logic [23:0]];
    logic [12:0] open_row [4];
    logic [31:0] pd [CL+1];
    logic        pv [CL+1];
    initial for (int k = 0; k <= CL; k++) begin pd[k] = '0; pv[k] = 1'b0; end

    always @(negedge CLK) begin
        logic [3:0]  c;
        logic [23:0] key;
        logic [31:0] w;
        c = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
        cmd_at[cyc] = c;  addr_at[cyc] = sdr_addr; ba_at[cyc] = sdr_ba;
        dqm_at[cyc] = sdr_dqm; oe_at[cyc] = sdr_dq_oe; dout_at[cyc] = sdr_dq_out;
        rsp_at[cyc] = rsp_valid; rdata_at[cyc] = rsp_rdata; idone_at[cyc] = init_done;
        if (rsp_valid) rsp_count++;
        for (int k = CL; k >= 1; k--) begin pd[k] = pd[k-1]; pv[k] = pv[k-1]; end
        pv[0] = 1'b0;
        key = {open_row[sdr_ba], sdr_ba, sdr_addr[8:0]};
        if (c == ACT) open_row[sdr_ba] = sdr_addr;
        if (c == WR) begin
            w = mem.exists(key) ? mem[key] : 32'h0;
            for (int b = 0; b < 4; b++) if (!sdr_dqm[b]) w[b*8 +: 8] = sdr_dq_out[b*8 +: 8];
            mem[key] = w;
        end
        if (c == RD) begin
            pd[0] = mem.exists(key) ? mem[key] : 32'h0;
            pv[0] = 1'b1;
        end
        sdr_dq_in = pv[CL] ? pd[CL] : 32'h0;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Present a request and wait for acceptance; leaves req_valid asserted.
    task automatic issue(input logic w, input logic [23:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int hcyc);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
        hcyc = -1;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                hcyc = cyc;
                break;
            end
            step();
        end
        if (hcyc < 0) check_eq("hs_timeout", 32'(req_ready), 32'd1);
        else step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd"}, {28'h0, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, 32'hF);
        check_eq({tag, "_cke"}, 32'(sdr_cke), 32'd0);
        check_eq({tag, "_addr_ba"}, {17'h0, sdr_addr, sdr_ba}, 32'h0);
        check_eq({tag, "_dqm"}, 32'(sdr_dqm), 32'hF);
        check_eq({tag, "_dq"}, {sdr_dq_out[30:0], sdr_dq_oe}, 32'h0);
        check_eq({tag, "_ctl"}, {29'h0, req_ready, rsp_valid, init_done}, 32'h0);
        check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
    endtask

    localparam logic [23:0] ADDR_A = 24'h00_1234;  // row 2, bank 1, col 0x34
    localparam logic [23:0] ADDR_B = 24'h0A_5C21;  // row 0x14B, bank 2, col 0x21

    initial begin
        int base, base2, h1, h2, h3, h4, h5, h6, h7, ha, hb, hc, nops, others, lows, refs;
        int rsp_before;

        repeat (3) step();
        check_reset_outputs("rst");

        // Power-up sequence.
        RST_N = 1'b1;
        base  = cyc;
        repeat (125) step();
        check_eq("cke_first", 32'(idone_at[base] === 1'b0 && cmd_at[base + 1] == NOP), 32'd1);
        nops = 0; others = 0;
        for (int k = 1; k <= 100; k++) if (cmd_at[base + k] == NOP) nops++;
        for (int k = 1; k <= 124; k++) if (cmd_at[base + k] != NOP) others++;
        check_eq("init_nops", 32'(nops), 32'd100);
        check_eq("init_cmd_count", 32'(others), 32'd4);
        check_eq("init_pre", {cmd_at[base + 101], 15'h0, addr_at[base + 101]}, {PRE, 28'h400});
        check_eq("init_ref1", 32'(cmd_at[base + 103]), 32'(REF));
        check_eq("init_ref2", 32'(cmd_at[base + 110]), 32'(REF));
        check_eq("init_lmr", {cmd_at[base + 117], 13'h0, ba_at[base + 117], addr_at[base + 117]},
                 {LMR, 28'h0030});
        check_eq("init_done_edge", {30'h0, idone_at[base + 118], idone_at[base + 119]}, 32'h1);
        check_eq("ready_idle", 32'(req_ready), 32'd1);

        // Full write then back-to-back read of the same word.
        issue(1'b1, ADDR_A, 32'hDEADBEEF, 4'hF, h1);
        issue(1'b0, ADDR_A, 32'h0, 4'h0, h2);
        req_valid = 1'b0;
        repeat (10) step();
        check_eq("wr_act", {cmd_at[h1 + 1], 13'h0, ba_at[h1 + 1], addr_at[h1 + 1]},
                 {ACT, 13'h0, 2'd1, 13'd2});
        check_eq("wr_cmd", {cmd_at[h1 + 3], 13'h0, ba_at[h1 + 3], addr_at[h1 + 3]},
                 {WR, 13'h0, 2'd1, 13'h434});
        check_eq("wr_data", dout_at[h1 + 3], 32'hDEADBEEF);
        check_eq("wr_oe_dqm", {27'h0, oe_at[h1 + 3], dqm_at[h1 + 3]}, 32'h10);
        check_eq("wr_to_next_hs", 32'(h2 - h1), 32'd8);
        check_eq("rd_cmd", {cmd_at[h2 + 1], cmd_at[h2 + 3], dqm_at[h2 + 3]}, {ACT, RD, 4'h0});
        check_eq("rd_rsp_pulse", {29'h0, rsp_at[h2 + 6], rsp_at[h2 + 7], rsp_at[h2 + 8]}, 32'h2);
        check_eq("rd_data", rdata_at[h2 + 7], 32'hDEADBEEF);

        // Byte-masked write over all-ones, then readback.
        issue(1'b1, ADDR_B, 32'hFFFFFFFF, 4'hF, h3);
        issue(1'b1, ADDR_B, 32'h11223344, 4'b0101, h4);
        check_eq("rdata_hold", rsp_rdata, 32'hDEADBEEF);
        issue(1'b0, ADDR_B, 32'h0, 4'h0, h5);
        req_valid = 1'b0;
        repeat (10) step();
        check_eq("mw_act", {cmd_at[h5 + 1], 13'h0, ba_at[h5 + 1], addr_at[h5 + 1]},
                 {ACT, 13'h0, 2'd2, 13'h14B});
        check_eq("mw_dqm", 32'(dqm_at[h4 + 3]), 32'b1010);
        check_eq("mw_rdata", rdata_at[h5 + 7], 32'hFF22FF44);

        // Periodic refresh: init_done at 119, pending at 899, REFRESH on bus at 900.
        lows = 0;
        while (cyc - base < 895) step();
        while (cyc - base <= 900) begin
            if (!req_ready) lows++;
            step();
        end
        issue(1'b0, ADDR_A, 32'h0, 4'h0, h6);
        req_valid = 1'b0;
        lows += h6 - (base + 901);
        repeat (10) step();
        refs = 0;
        for (int k = 120; k <= 906; k++) if (cmd_at[base + k] == REF) refs++;
        check_eq("ref_cycle", 32'(cmd_at[base + 900]), 32'(REF));
        check_eq("ref_count", 32'(refs), 32'd1);
        check_eq("ref_ready_low", 32'(lows), 32'd8);
        check_eq("ref_then_hs", 32'(h6 - base), 32'd907);
        check_eq("ref_rd_data", rdata_at[h6 + 7], 32'hDEADBEEF);

        // Reset between READ and capture aborts the read and restarts init.
        rsp_before = rsp_count;
        issue(1'b0, ADDR_B, 32'h0, 4'h0, h7);
        req_valid = 1'b0;
        step(); step();
        step();
        RST_N = 1'b0;
        step();
        check_reset_outputs("midrst");
        RST_N = 1'b1;
        base2 = cyc;
        repeat (125) step();
        check_eq("midrst_no_rsp", 32'(rsp_count - rsp_before), 32'd0);
        check_eq("midrst_pre", 32'(cmd_at[base2 + 101]), 32'(PRE));
        check_eq("midrst_lmr", 32'(cmd_at[base2 + 117]), 32'(LMR));
        check_eq("midrst_done", {30'h0, idone_at[base2 + 118], idone_at[base2 + 119]}, 32'h1);

        // Back-to-back reads with req_valid held.
        rsp_before = rsp_count;
        issue(1'b0, ADDR_A, 32'h0, 4'h0, ha);
        issue(1'b0, ADDR_B, 32'h0, 4'h0, hb);
        issue(1'b0, ADDR_A, 32'h0, 4'h0, hc);
        req_valid = 1'b0;
        repeat (12) step();
        check_eq("b2b_gap1", 32'(hb - ha), 32'd8);
        check_eq("b2b_gap2", 32'(hc - hb), 32'd8);
        check_eq("b2b_pulses", 32'(rsp_count - rsp_before), 32'd3);
        check_eq("b2b_d0", rdata_at[ha + 7], 32'hDEADBEEF);
        check_eq("b2b_d1", rdata_at[hb + 7], 32'hFF22FF44);
        check_eq("b2b_d2", rdata_at[hc + 7], 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
